// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter feeding the FND digit scanner.
// Optional leading-zero blank mask: define LEADING_ZERO_BLANK_EN.
module bin2bcd_seq #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 8
) (
  input  logic                  sysclk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int ITER_W = $clog2(BIN_W + 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(BIN_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic               sticky_q, sticky_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic               ovf_q, ovf_d;

  logic [BCD_W-1:0]   work_adj;
  logic [BCD_W-1:0]   work_shift;
  logic [BIN_W-1:0]   bin_shift;
  logic               sticky_next;

  // Add-3 correction per digit, then one left shift of {BCD, bin}
  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
    work_shift  = {work_adj[BCD_W-2:0], shift_q[BIN_W-1]};
    bin_shift   = {shift_q[BIN_W-2:0], 1'b0};
    sticky_next = sticky_q | work_adj[BCD_W-1];
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    work_d    = work_q;
    sticky_d  = sticky_q;
    iter_d    = iter_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_out_d = bcd_out_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d  = bin_in;
          work_d   = '0;
          sticky_d = 1'b0;
          iter_d   = '0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        shift_d  = bin_shift;
        work_d   = work_shift;
        sticky_d = sticky_next;
        iter_d   = iter_q + 1'b1;
        if (iter_q == LAST_ITER) begin
          bcd_out_d = work_shift;
          ovf_d     = sticky_next;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      work_q    <= '0;
      sticky_q  <= 1'b0;
      iter_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_out_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      work_q    <= work_d;
      sticky_q  <= sticky_d;
      iter_q    <= iter_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_out_q <= bcd_out_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              upper_zero;

  // Digit 0 is never blanked so a zero value still shows one "0"
  always_comb begin
    blank_d    = blank_q;
    upper_zero = 1'b1;
    if (state_q == SHIFT && iter_q == LAST_ITER) begin
      blank_d = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        upper_zero = upper_zero & (work_shift[4*i +: 4] == 4'd0);
        blank_d[i] = upper_zero;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) blank_q <= '0;
    else       blank_q <= blank_d;
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_out_q;
  assign ovf     = ovf_q;

endmodule
